// File: rtl/my_subtractor.sv
// ---------------------------------------------------------------------------
// my_subtractor
//   32-bit unsigned subtractor with borrow-in and registered outputs.
//   The difference is formed as S = A + ~B + ~C0 through a 32-cell
//   ripple-carry chain of 1-bit full adders.
//   Res = S[31:0] = (A - B - C0) mod 2^32.
//   C   = S[32], which is 1 when no borrow occurred (A >= B + C0).
//   Latency is one cycle, and a new operand set is accepted on every clock.
//
// Ports
//   clk   in   1   sole clock, rising edge
//   rst_n in   1   asynchronous active-low reset; clears Res and C
//   A     in  32   minuend, unsigned
//   B     in  32   subtrahend, unsigned
//   C0    in   1   borrow-in (1 = subtract one extra)
//   Res   out 32   registered difference
//   C     out  1   registered carry-out (1 = no borrow, 0 = borrow)
// ---------------------------------------------------------------------------

// One cell of the chain. The subtrahend bit is inverted here, so the
// chain adds ~B to A.
module my_subtractor_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic nb;

  assign nb     = ~b_i;
  assign sum_o  = a_i ^ nb ^ cin_i;
  assign cout_o = (a_i & nb) | (a_i & cin_i) | (nb & cin_i);
endmodule

module my_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C0,
  output logic [31:0] Res,
  output logic        C
);
  logic [32:0] carry;
  logic [31:0] res_d;
  logic        c_d;
  logic [31:0] res_q;
  logic        c_q;

  // Borrow-in enters the chain inverted: ~C0 supplies the "+1" of the
  // two's complement of B when there is no borrow.
  assign carry[0] = ~C0;

  for (genvar i = 0; i < 32; i++) begin : g_chain
    my_subtractor_fa u_fa (
      .a_i   (A[i]),
      .b_i   (B[i]),
      .cin_i (carry[i]),
      .sum_o (res_d[i]),
      .cout_o(carry[i+1])
    );
  end

  assign c_d = carry[32];

  // ---- stage boundary: operand chain -> registered result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 32'h0000_0000;
      c_q   <= 1'b0;
    end else begin
      res_q <= res_d;
      c_q   <= c_d;
    end
  end

  assign Res = res_q;
  assign C   = c_q;
endmodule

// File: tb/tb_my_subtractor.sv
module tb_my_subtractor;
  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        C0;
  logic [31:0] Res;
  logic        C;

  int checks   = 0;
  int failures = 0;

  my_subtractor dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .C0   (C0),
    .Res  (Res),
    .C    (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed and expected are {C, Res}.
  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got C=%0b Res=%08h, want C=%0b Res=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Drive the operands on the falling edge, let one rising edge capture
  // them, then check the outputs 1 ns later.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c0, input logic [31:0] er, input logic ec);
    @(negedge clk);
    A = a; B = b; C0 = c0;
    @(posedge clk);
    #1;
    chk(tag, {C, Res}, {ec, er});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    A = 32'h1234_5678; B = 32'h0000_0001; C0 = 1'b0;
    #1;
    chk("reset_t0", {C, Res}, 33'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {C, Res}, 33'h0);
    end

    // Release reset on a falling edge; the first result follows the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    A = 32'h0000_0003; B = 32'h0000_0001; C0 = 1'b0;
    #1;
    chk("release_no_edge", {C, Res}, 33'h0);
    @(posedge clk);
    #1;
    chk("basic", {C, Res}, {1'b1, 32'h0000_0002});

    apply("negative",    32'h0000_0008, 32'h0000_0018, 1'b0, 32'hFFFF_FFF0, 1'b0);
    apply("borrow_in",   32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b0);
    apply("equal",       32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1);
    apply("ext_zero",    32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0);
    apply("ext_max",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b1);
    apply("msb_step",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1);
    apply("zero_borrow", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
    apply("max_max_b",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
    apply("mid",         32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000, 1'b1);
    apply("a_gt_b_brw",  32'h0000_0006, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1);
    apply("alt_bits",    32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h5555_5555, 1'b1);
    apply("alt_bits_r",  32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 32'hAAAA_AAAB, 1'b0);

    // Inputs changing between edges leave the registered outputs alone.
    @(negedge clk);
    A = 32'h0000_0000; B = 32'h0000_0001; C0 = 1'b1;
    #2;
    chk("hold_between_edges", {C, Res}, {1'b0, 32'hAAAA_AAAB});
    @(posedge clk);
    #1;
    chk("hold_then_capture", {C, Res}, {1'b0, 32'hFFFF_FFFE});

    // Back-to-back operands: each one shows up exactly one edge later.
    @(negedge clk);
    A = 32'd100; B = 32'd1; C0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_0", {C, Res}, {1'b1, 32'd99});
    A = 32'd200; B = 32'd50; C0 = 1'b1;
    #2;
    chk("b2b_0_hold", {C, Res}, {1'b1, 32'd99});
    @(posedge clk); #1;
    chk("b2b_1", {C, Res}, {1'b1, 32'd149});
    A = 32'd7; B = 32'd9; C0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_2", {C, Res}, {1'b0, 32'hFFFF_FFFE});

    // Reset pulse between two edges clears at once and discards the pending result.
    A = 32'd40; B = 32'd10; C0 = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midstream_reset", {C, Res}, 33'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("after_pulse_no_edge", {C, Res}, 33'h0);
    @(posedge clk); #1;
    chk("resume", {C, Res}, {1'b1, 32'd30});
    apply("resume_next", 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
